// File: rtl/pz_stream_pkg.sv
// Shared definitions for the pole/zero frame streamer: pixel packing modes,
// FSM state type, shadow-index width helper and byte-lane positions.
package pz_stream_pkg;

  localparam int unsigned PIX_PACKED = 0;  // RGB888, 4 pixels -> 3 words
  localparam int unsigned PIX_XRGB   = 1;  // xRGB, 1 pixel -> 1 word

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } pz_state_e;

  // Byte position of each colour inside a 24-bit pixel {r,g,b}
  localparam int unsigned LANE_B = 0;
  localparam int unsigned LANE_G = 1;
  localparam int unsigned LANE_R = 2;

  function automatic int unsigned root_idx_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(2 * n);
  endfunction

endpackage

// File: rtl/pz_frame_streamer_if.sv
// AXI4-Stream video bus (32-bit) used between the streamer and its sink.
//   tdata/tkeep/tlast/tuser/tvalid : master -> slave
//   tready                         : slave  -> master
interface pz_frame_streamer_if;

  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);

endinterface

// File: rtl/pz_rgb_packer.sv
// Packs RGB pixels into 32-bit stream words behind a single output register.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_valid          : pixel accepted this cycle (must only be high when o_ready)
//   i_r/i_g/i_b      : pixel colour
//   i_sof, i_eol     : pixel is first of frame / last of line
//   o_ready          : output register can take a new word this cycle
//   m_axis           : AXI4-Stream master
module pz_rgb_packer
  import pz_stream_pkg::*;
#(
  parameter int unsigned PIX_MODE = PIX_PACKED
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [7:0]           i_r,
  input  logic [7:0]           i_g,
  input  logic [7:0]           i_b,
  input  logic                 i_sof,
  input  logic                 i_eol,
  output logic                 o_ready,
  pz_frame_streamer_if.master  m_axis
);

  logic [23:0] w_pix;
  logic        w_word;
  logic [31:0] w_data;

  logic [1:0]  r_phase;
  logic [23:0] r_res;
  logic        r_sof_pend;
  logic [31:0] r_tdata;
  logic        r_tlast;
  logic        r_tuser;
  logic        r_tvalid;

  always_comb begin
    w_pix = '0;
    w_pix[8*LANE_B +: 8] = i_b;
    w_pix[8*LANE_G +: 8] = i_g;
    w_pix[8*LANE_R +: 8] = i_r;
  end

  // Byte stream is LSB-first; the residue holds the bytes not yet placed in a word.
  always_comb begin
    w_word = 1'b1;
    w_data = {8'h00, w_pix};
    if (PIX_MODE == PIX_PACKED) begin
      unique case (r_phase)
        2'd0: w_word = 1'b0;
        2'd1: w_data = {w_pix[7:0], r_res};
        2'd2: w_data = {w_pix[15:0], r_res[15:0]};
        2'd3: w_data = {w_pix, r_res[7:0]};
      endcase
    end
  end

  assign o_ready = ~r_tvalid | m_axis.tready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase    <= '0;
      r_res      <= '0;
      r_sof_pend <= 1'b0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
      r_tvalid   <= 1'b0;
    end else if (i_valid) begin
      r_phase <= r_phase + 2'd1;
      unique case (r_phase)
        2'd0: r_res <= w_pix;
        2'd1: r_res <= {8'h00, w_pix[23:8]};
        2'd2: r_res <= {16'h0000, w_pix[23:16]};
        2'd3: r_res <= '0;
      endcase
      if (w_word) begin
        r_tdata    <= w_data;
        r_tvalid   <= 1'b1;
        r_tlast    <= i_eol;
        r_tuser    <= i_sof | r_sof_pend;
        r_sof_pend <= 1'b0;
      end else begin
        // SOF pixel produced no word yet; carry the flag to the word it starts
        r_sof_pend <= i_sof;
        if (m_axis.tready) r_tvalid <= 1'b0;
      end
    end else if (m_axis.tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tkeep  = 4'hF;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = r_tuser;
  assign m_axis.tvalid = r_tvalid;

endmodule

// File: rtl/pz_frame_streamer.sv
// Scans a WIDTH x HEIGHT frame, presents signed centred coordinates to an
// external colour pipeline and streams the returned colours as AXI4-Stream.
//   out_stream_aclk, periph_reset : clock, synchronous active-high reset
//   enable                        : run frames; low stops at next frame end
//   cfg_wr_en/idx/data            : shadow root bank write
//   roots_active                  : active root bank, index 0 in LSBs
//   pix_x, pix_y, pix_valid       : current coordinate to colour pipeline
//   pix_r/g/b                     : colour for the current coordinate
//   out_stream                    : AXI4-Stream video master
//   frame_cnt                     : completed frames
module pz_frame_streamer
  import pz_stream_pkg::*;
#(
  parameter  int unsigned WIDTH     = 640,
  parameter  int unsigned HEIGHT    = 480,
  parameter  int unsigned NUM_ROOTS = 4,
  parameter  int unsigned PIX_MODE  = PIX_PACKED,
  parameter  int unsigned COORD_W   = 16,
  localparam int unsigned IDX_W     = root_idx_w(NUM_ROOTS)
) (
  input  logic                      out_stream_aclk,
  input  logic                      periph_reset,
  input  logic                      enable,
  input  logic                      cfg_wr_en,
  input  logic [IDX_W-1:0]          cfg_wr_idx,
  input  logic [31:0]               cfg_wr_data,
  output logic [64*NUM_ROOTS-1:0]   roots_active,
  output logic signed [COORD_W-1:0] pix_x,
  output logic signed [COORD_W-1:0] pix_y,
  output logic                      pix_valid,
  input  logic [7:0]                pix_r,
  input  logic [7:0]                pix_g,
  input  logic [7:0]                pix_b,
  pz_frame_streamer_if.master       out_stream,
  output logic [15:0]               frame_cnt
);

  localparam int unsigned          NUM_WORDS = 2 * NUM_ROOTS;
  localparam logic [COORD_W-1:0]   LAST_COL  = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0]   LAST_ROW  = COORD_W'(HEIGHT - 1);

  pz_state_e                         r_state;
  logic [COORD_W-1:0]                r_col;
  logic [COORD_W-1:0]                r_row;
  logic [15:0]                       r_frame_cnt;
  logic [NUM_WORDS-1:0][31:0]        r_shadow;
  logic [NUM_WORDS-1:0][31:0]        r_active;

  logic w_ready;
  logic w_pix_accept;
  logic w_last_pix;
  logic w_sof;
  logic w_eol;

  assign pix_valid    = (r_state == ST_RUN);
  assign w_pix_accept = pix_valid & w_ready;
  assign w_eol        = (r_col == LAST_COL);
  assign w_sof        = (r_col == '0) & (r_row == '0);
  assign w_last_pix   = w_pix_accept & w_eol & (r_row == LAST_ROW);

  assign pix_x        = r_col - COORD_W'(WIDTH / 2);
  assign pix_y        = COORD_W'(HEIGHT / 2) - r_row;
  assign roots_active = r_active;
  assign frame_cnt    = r_frame_cnt;

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_frame_cnt <= '0;
      r_shadow    <= '0;
      r_active    <= '0;
    end else begin
      if (cfg_wr_en && (32'(cfg_wr_idx) < NUM_WORDS))
        r_shadow[cfg_wr_idx] <= cfg_wr_data;
      // Commit sees the pre-write shadow: a same-cycle cfg write waits for the next commit
      if (w_last_pix || (r_state == ST_IDLE))
        r_active <= r_shadow;
      if (w_last_pix)
        r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_pix_accept) begin
        if (w_eol) begin
          r_col <= '0;
          r_row <= (r_row == LAST_ROW) ? '0 : r_row + COORD_W'(1);
        end else begin
          r_col <= r_col + COORD_W'(1);
        end
      end
      unique case (r_state)
        ST_IDLE: if (enable) r_state <= ST_RUN;
        ST_RUN:  if (w_last_pix && !enable) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pz_rgb_packer #(
    .PIX_MODE (PIX_MODE)
  ) u_packer (
    .i_clk   (out_stream_aclk),
    .i_rst   (periph_reset),
    .i_valid (w_pix_accept),
    .i_r     (pix_r),
    .i_g     (pix_g),
    .i_b     (pix_b),
    .i_sof   (w_sof),
    .i_eol   (w_eol),
    .o_ready (w_ready),
    .m_axis  (out_stream)
  );

endmodule

// File: tb/tb_pz_frame_streamer.sv
// Bench for pz_frame_streamer: one instance per packing mode on an 8x2 frame.
module tb_pz_frame_streamer;
  import pz_stream_pkg::*;

  localparam int W     = 8;
  localparam int H     = 2;
  localparam int NR    = 4;
  localparam int CW    = 16;
  localparam int IDXW  = root_idx_w(NR);
  localparam int LASTX = W - 1 - W / 2;
  localparam int LASTY = H / 2 - (H - 1);

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        user;
  } word_t;

  typedef struct {
    int unsigned dut;
    int unsigned idx;
    logic [31:0] data;
    logic        last;
    logic        user;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  [2];
  logic rdy [2] = '{1'b1, 1'b1};
  logic rnd_rdy = 1'b0;
  logic chk_stable = 1'b0;
  logic cfg_we;
  logic [IDXW-1:0] cfg_idx;
  logic [31:0] cfg_data;
  int unsigned seed = 0;

  logic [64*NR-1:0]     roots [2];
  logic signed [CW-1:0] px [2];
  logic signed [CW-1:0] py [2];
  logic                 pv [2];
  logic [7:0]           pr [2];
  logic [7:0]           pg [2];
  logic [7:0]           pb [2];
  logic [15:0]          fcnt [2];
  logic                 tv [2];
  logic                 tl [2];
  logic                 tu [2];
  logic [31:0]          td [2];
  logic [3:0]           tk [2];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  word_t cap0[$];
  word_t cap1[$];
  vec_t  tbl [11];

  pz_frame_streamer_if if0 ();
  pz_frame_streamer_if if1 ();

  assign if0.tready = rdy[0];
  assign if1.tready = rdy[1];
  assign tv[0] = if0.tvalid;  assign tv[1] = if1.tvalid;
  assign tl[0] = if0.tlast;   assign tl[1] = if1.tlast;
  assign tu[0] = if0.tuser;   assign tu[1] = if1.tuser;
  assign td[0] = if0.tdata;   assign td[1] = if1.tdata;
  assign tk[0] = if0.tkeep;   assign tk[1] = if1.tkeep;

  // Colour pipeline stand-in; seed 0 gives r=g=b=col
  function automatic logic [23:0] colour(input int col, input int row, input int unsigned s);
    if (s == 0) return {3{8'(col)}};
    return {8'(col * 37 + row * 11 + int'(s)), 8'(col ^ int'(s)), 8'(row * 5 + col * 3 + int'(s >> 8))};
  endfunction

  assign {pr[0], pg[0], pb[0]} = colour(int'(px[0]) + W / 2, H / 2 - int'(py[0]), seed);
  assign {pr[1], pg[1], pb[1]} = colour(int'(px[1]) + W / 2, H / 2 - int'(py[1]), seed);

  pz_frame_streamer #(
    .WIDTH (W), .HEIGHT (H), .NUM_ROOTS (NR), .PIX_MODE (PIX_PACKED), .COORD_W (CW)
  ) u_dut0 (
    .out_stream_aclk (clk),      .periph_reset (rst),       .enable (en[0]),
    .cfg_wr_en       (cfg_we),   .cfg_wr_idx   (cfg_idx),   .cfg_wr_data (cfg_data),
    .roots_active    (roots[0]), .pix_x        (px[0]),     .pix_y (py[0]),
    .pix_valid       (pv[0]),    .pix_r        (pr[0]),     .pix_g (pg[0]),
    .pix_b           (pb[0]),    .out_stream   (if0),       .frame_cnt (fcnt[0])
  );

  pz_frame_streamer #(
    .WIDTH (W), .HEIGHT (H), .NUM_ROOTS (NR), .PIX_MODE (PIX_XRGB), .COORD_W (CW)
  ) u_dut1 (
    .out_stream_aclk (clk),      .periph_reset (rst),       .enable (en[1]),
    .cfg_wr_en       (cfg_we),   .cfg_wr_idx   (cfg_idx),   .cfg_wr_data (cfg_data),
    .roots_active    (roots[1]), .pix_x        (px[1]),     .pix_y (py[1]),
    .pix_valid       (pv[1]),    .pix_r        (pr[1]),     .pix_g (pg[1]),
    .pix_b           (pb[1]),    .out_stream   (if1),       .frame_cnt (fcnt[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rdy[0] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    rdy[1] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Capture accepted words and check that stalled words are held
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic  stall_q = 1'b0;
    word_t prev_q;
    always @(negedge clk) begin
      if (tv[g] && rdy[g]) begin
        if (g == 0) cap0.push_back({td[g], tl[g], tu[g]});
        else        cap1.push_back({td[g], tl[g], tu[g]});
      end
      if (chk_stable && stall_q)
        check($sformatf("stall_hold_m%0d", g), {29'd0, tv[g], td[g], tl[g], tu[g]},
              {29'd0, 1'b1, prev_q});
      stall_q <= tv[g] && !rdy[g];
      prev_q  <= {td[g], tl[g], tu[g]};
    end
  end

  // Reference: words per frame and k-th word of a frame from the byte stream
  function automatic int wpf(input int mode);
    return (mode == 0) ? W * H * 3 / 4 : W * H;
  endfunction

  function automatic word_t model_word(input int mode, input int k);
    word_t       w;
    logic [23:0] p;
    int          b;
    int          pix;
    w = '0;
    if (mode == 1) begin
      p      = colour(k % W, k / W, seed);
      w.data = {8'h00, p};
      w.last = (k % W == W - 1);
    end else begin
      for (int j = 0; j < 4; j++) begin
        b   = 4 * k + j;
        pix = b / 3;
        p   = colour(pix % W, pix / W, seed);
        w.data[8*j +: 8] = p[8*(b % 3) +: 8];
        if (b % (3 * W) == 3 * W - 1) w.last = 1'b1;
      end
    end
    w.user = (k == 0);
    return w;
  endfunction

  task automatic check_stream(input int d, input int nframes, input string name);
    int    n;
    int    got_n;
    word_t g;
    n     = nframes * wpf(d);
    got_n = (d == 0) ? cap0.size() : cap1.size();
    check({name, "_count"}, 64'(got_n), 64'(n));
    for (int i = 0; i < n && i < got_n; i++) begin
      g = (d == 0) ? cap0[i] : cap1[i];
      check($sformatf("%s_w%0d", name, i), 64'(g), 64'(model_word(d, i % wpf(d))));
    end
    if (d == 0) cap0.delete();
    else        cap1.delete();
  endtask

  task automatic wait_idle(input int d, input string name);
    int c;
    c = 0;
    while ((pv[d] || tv[d]) && c < 400) begin
      @(negedge clk);
      c++;
    end
    check({name, "_idle"}, {62'd0, pv[d], tv[d]}, 64'd0);
  endtask

  task automatic run_frames(input int d, input int n, input string name);
    int unsigned start;
    int          c;
    start = fcnt[d];
    en[d] = 1'b1;
    c = 0;
    while (!pv[d] && c < 20) begin
      @(negedge clk);
      c++;
    end
    c = 0;
    while (fcnt[d] != 16'(start + n - 1) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check({name, "_fcnt_reach"}, 64'(fcnt[d]), 64'(16'(start + n - 1)));
    en[d] = 1'b0;
    wait_idle(d, name);
    check({name, "_fcnt"}, 64'(fcnt[d]), 64'(16'(start + n)));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_act;
    logic [31:0] shadow_m;
    logic [31:0] next_act;
    logic [15:0] exp_fc;
    logic        commit;
    logic        wrote;
    logic        we;
    int          n_commit;
    int          acc;
    word_t       g;

    en[0] = 1'b0; en[1] = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;

    tbl[0]  = '{0, 0,  32'h01000000, 1'b0, 1'b1};
    tbl[1]  = '{0, 1,  32'h02020101, 1'b0, 1'b0};
    tbl[2]  = '{0, 2,  32'h03030302, 1'b0, 1'b0};
    tbl[3]  = '{0, 5,  32'h07070706, 1'b1, 1'b0};
    tbl[4]  = '{0, 6,  32'h01000000, 1'b0, 1'b0};
    tbl[5]  = '{0, 11, 32'h07070706, 1'b1, 1'b0};
    tbl[6]  = '{1, 0,  32'h00000000, 1'b0, 1'b1};
    tbl[7]  = '{1, 3,  32'h00030303, 1'b0, 1'b0};
    tbl[8]  = '{1, 7,  32'h00070707, 1'b1, 1'b0};
    tbl[9]  = '{1, 8,  32'h00000000, 1'b0, 1'b0};
    tbl[10] = '{1, 15, 32'h00070707, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_tvalid_m%0d", d), 64'(tv[d]), 64'd0);
      check($sformatf("rst_tdata_m%0d", d), 64'(td[d]), 64'd0);
      check($sformatf("rst_tlast_tuser_m%0d", d), {62'd0, tl[d], tu[d]}, 64'd0);
      check($sformatf("rst_tkeep_m%0d", d), 64'(tk[d]), 64'hF);
      check($sformatf("rst_pix_valid_m%0d", d), 64'(pv[d]), 64'd0);
      check($sformatf("rst_fcnt_m%0d", d), 64'(fcnt[d]), 64'd0);
      check($sformatf("rst_roots_m%0d", d), 64'(|roots[d]), 64'd0);
    end

    // One frame, r=g=b=col, tready=1, enable dropped in row 0
    fork
      run_frames(0, 1, "t1m0");
      run_frames(1, 1, "t1m1");
    join
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].idx < ((tbl[i].dut == 0) ? cap0.size() : cap1.size())) begin
        g = (tbl[i].dut == 0) ? cap0[tbl[i].idx] : cap1[tbl[i].idx];
        check($sformatf("tbl_m%0d_w%0d", tbl[i].dut, tbl[i].idx), 64'(g),
              64'({tbl[i].data, tbl[i].last, tbl[i].user}));
      end else begin
        check($sformatf("tbl_m%0d_missing_w%0d", tbl[i].dut, tbl[i].idx),
              64'((tbl[i].dut == 0) ? cap0.size() : cap1.size()), 64'(tbl[i].idx + 1));
      end
    end
    check_stream(0, 1, "t1m0");
    check_stream(1, 1, "t1m1");

    // Random backpressure: same frame, then two frames of hashed colours
    rnd_rdy    = 1'b1;
    chk_stable = 1'b1;
    fork
      run_frames(0, 1, "t3m0");
      run_frames(1, 1, "t3m1");
    join
    check_stream(0, 1, "t3m0");
    check_stream(1, 1, "t3m1");
    seed = $urandom | 32'h1;
    fork
      run_frames(0, 2, "t3rm0");
      run_frames(1, 2, "t3rm1");
    join
    check_stream(0, 2, "t3rm0");
    check_stream(1, 2, "t3rm1");
    rnd_rdy = 1'b0;
    seed    = 0;
    repeat (2) @(negedge clk);
    chk_stable = 1'b0;

    // Reset pulse after pixel 5 of a frame
    en[0] = 1'b1; en[1] = 1'b1;
    acc = 0;
    for (int c = 0; c < 50 && acc < 5; c++) begin
      @(negedge clk);
      if (pv[0] && (!tv[0] || rdy[0])) acc++;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t5_tvalid_m%0d", d), 64'(tv[d]), 64'd0);
      check($sformatf("t5_pv_m%0d", d), 64'(pv[d]), 64'd0);
      check($sformatf("t5_fcnt_m%0d", d), 64'(fcnt[d]), 64'd0);
    end
    cap0.delete();
    cap1.delete();
    fork
      run_frames(0, 1, "t5m0");
      run_frames(1, 1, "t5m1");
    join
    check_stream(0, 1, "t5m0");
    check_stream(1, 1, "t5m1");

    // Shadow/active commit, including a cfg write in the commit cycle
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_act  = '0;
    shadow_m = '0;
    exp_fc   = '0;
    wrote    = 1'b0;
    n_commit = 0;
    en[0]    = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("t4_active", 64'(roots[0][31:0]), 64'(exp_act));
      check("t4_fcnt", 64'(fcnt[0]), 64'(exp_fc));
      if (pv[0]) en[0] = 1'b0;
      commit = pv[0] && (px[0] == LASTX) && (py[0] == LASTY) && (!tv[0] || rdy[0]);
      we = 1'b0;
      if (pv[0] && !wrote && (px[0] == 2 - W / 2)) begin
        cfg_data = 32'h00010002;
        we       = 1'b1;
        wrote    = 1'b1;
      end else if (commit) begin
        cfg_data = 32'hAAAA5555;
        we       = 1'b1;
      end
      cfg_idx  = '0;
      cfg_we   = we;
      next_act = (commit || !pv[0]) ? shadow_m : exp_act;
      if (we) shadow_m = cfg_data;
      if (commit) begin
        exp_fc++;
        n_commit++;
      end
      @(posedge clk);
      #1 cfg_we = 1'b0;
      exp_act = next_act;
    end
    check("t4_commits", 64'(n_commit), 64'd1);
    check("t4_active_final", 64'(roots[0][31:0]), 64'hAAAA5555);
    check("t4_active_upper", 64'(|roots[0][64*NR-1:32]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
